// File: rtl/pc_redirect_if.sv
// Fetch-PC sequencer bundle: decode redirect inputs, exception redirect and fetch PC outputs.
// Optional BRANCH_STATS_EN adds the branch/taken counter outputs.
interface pc_redirect_if;
  logic        stallF;
  logic        stallD;
  logic        validD;
  logic        branchD;
  logic        takenD;
  logic        jumpD;
  logic        jrD;
  logic [31:0] pcplus4D;
  logic [31:0] immD;
  logic [25:0] instr_indexD;
  logic [31:0] rs_valD;
  logic        flush_exc;
  logic [31:0] exc_pc;
  logic [31:0] pcF;
  logic [31:0] pcplus4F;
  logic        redirect;
  logic        pend;
  logic        misalignF;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;
`endif

  modport master (
    output stallF, stallD, validD, branchD, takenD, jumpD, jrD,
           pcplus4D, immD, instr_indexD, rs_valD, flush_exc, exc_pc,
`ifdef BRANCH_STATS_EN
    input  branch_cnt, taken_cnt,
`endif
    input  pcF, pcplus4F, redirect, pend, misalignF
  );

  modport slave (
    input  stallF, stallD, validD, branchD, takenD, jumpD, jrD,
           pcplus4D, immD, instr_indexD, rs_valD, flush_exc, exc_pc,
`ifdef BRANCH_STATS_EN
    output branch_cnt, taken_cnt,
`endif
    output pcF, pcplus4F, redirect, pend, misalignF
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Fetch PC register and next-PC sequencer with a pending-redirect slot for fetch stalls.
// Optional BRANCH_STATS_EN adds free-running branch/taken counters.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic          clk,
  input  logic          rst,
  pc_redirect_if.slave  bus
);

  // state   | meaning
  // ST_RUN  | sequential fetch or immediate redirect
  // ST_PEND | a decode redirect arrived during stallF and waits in pend_pc_q
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        redirect_q, redirect_d;

  logic        req;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic        unused_imm;

  assign req       = bus.validD & ~bus.stallD & (bus.jrD | bus.jumpD | (bus.branchD & bus.takenD));
  assign br_target = bus.pcplus4D + {bus.immD[29:0], 2'b00};
  assign j_target  = {bus.pcplus4D[31:28], bus.instr_indexD, 2'b00};
  assign unused_imm = ^bus.immD[31:30];

  always_comb begin
    target = br_target;
    if (bus.jrD)
      target = bus.rs_valD;
    else if (bus.jumpD)
      target = j_target;
  end

  always_comb begin
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    state_d    = state_q;
    redirect_d = 1'b0;
    if (bus.flush_exc) begin
      pc_d       = bus.exc_pc;
      redirect_d = 1'b1;
      state_d    = ST_RUN;
      pend_pc_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (req && !bus.stallF) begin
            pc_d       = target;
            redirect_d = 1'b1;
          end else if (req) begin
            pend_pc_d = target;
            state_d   = ST_PEND;
          end else if (!bus.stallF) begin
            pc_d = pc_q + 32'd4;
          end
        end
        ST_PEND: begin
          // A redirect arriving in the same cycle fetch resumes is younger than the pending one.
          if (!bus.stallF) begin
            pc_d       = req ? target : pend_pc_q;
            redirect_d = 1'b1;
            state_d    = ST_RUN;
          end else if (req) begin
            pend_pc_d = target;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      state_q    <= ST_RUN;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      state_q    <= state_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.pcF       = pc_q;
  assign bus.pcplus4F  = pc_q + 32'd4;
  assign bus.redirect  = redirect_q;
  assign bus.pend      = (state_q == ST_PEND);
  assign bus.misalignF = (pc_q[1:0] != 2'b00);

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic        br_seen;

  assign br_seen = bus.validD & ~bus.stallD & bus.branchD;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (br_seen) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (bus.takenD)
        taken_cnt_d = taken_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.branch_cnt = branch_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed scenarios then random traffic vs a reference model.
module tb_pc_redirect_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk;
  logic rst;
  pc_redirect_if bus();

  pc_redirect_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic        pend;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  // Reference model: architectural PC plus at most one outstanding redirect target.
  logic [31:0] pc_m;
  logic [31:0] waiting[$];
  int unsigned br_m, tk_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.stallF = 0; bus.stallD = 0; bus.validD = 0; bus.branchD = 0; bus.takenD = 0;
    bus.jumpD = 0; bus.jrD = 0; bus.pcplus4D = 0; bus.immD = 0; bus.instr_indexD = 0;
    bus.rs_valD = 0; bus.flush_exc = 0; bus.exc_pc = 0;
  endtask

  function automatic void model_reset();
    pc_m = RESET_PC;
    waiting.delete();
    br_m = 0;
    tk_m = 0;
  endfunction

  // Uses the inputs currently driven, predicts the state after the next edge, then waits for it.
  task automatic apply();
    exp_t        e;
    logic        rq;
    logic [31:0] tgt;
    rq = bus.validD && !bus.stallD && (bus.jrD || bus.jumpD || (bus.branchD && bus.takenD));
    if (bus.jrD)        tgt = bus.rs_valD;
    else if (bus.jumpD) tgt = (bus.pcplus4D & 32'hF000_0000) | (32'(bus.instr_indexD) * 4);
    else                tgt = bus.pcplus4D + bus.immD * 4;
    if (bus.validD && !bus.stallD && bus.branchD) begin
      br_m++;
      if (bus.takenD) tk_m++;
    end
    e.redir = 1'b0;
    if (bus.flush_exc) begin
      pc_m = bus.exc_pc;
      waiting.delete();
      e.redir = 1'b1;
    end else begin
      if (rq) begin
        waiting.delete();
        waiting.push_back(tgt);
      end
      if (!bus.stallF) begin
        if (waiting.size() > 0) begin
          pc_m = waiting.pop_front();
          e.redir = 1'b1;
        end else begin
          pc_m = pc_m + 4;
        end
      end
    end
    e.pc   = pc_m;
    e.pend = (waiting.size() > 0);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pcF", bus.pcF, e.pc);
        chk("redirect", 32'(bus.redirect), 32'(e.redir));
        chk("pend", 32'(bus.pend), 32'(e.pend));
        chk("pcplus4F", bus.pcplus4F, e.pc + 32'd4);
        chk("misalignF", 32'(bus.misalignF), 32'(e.pc[1:0] != 2'b00));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_pcF", bus.pcF, RESET_PC);
    chk("reset_redirect", 32'(bus.redirect), 32'd0);
    chk("reset_pend", 32'(bus.pend), 32'd0);
    rst = 1'b0;

    // Sequential fetch after reset
    repeat (3) apply();
    chk("seq_pcF", bus.pcF, 32'hBFC0_000C);

    // Taken branch: 0x100 + (-4 << 2)
    bus.validD = 1; bus.branchD = 1; bus.takenD = 1;
    bus.pcplus4D = 32'h100; bus.immD = 32'hFFFF_FFFC;
    apply();
    chk("beq_pcF", bus.pcF, 32'h0000_00F0);
    chk("beq_redirect", 32'(bus.redirect), 32'd1);
    idle();
    apply();
    chk("beq_redirect_pulse", 32'(bus.redirect), 32'd0);

    // Jump during a 4-cycle fetch stall
    bus.validD = 1; bus.jumpD = 1; bus.stallF = 1;
    bus.pcplus4D = 32'h8000_0010; bus.instr_indexD = 26'h0000040;
    apply();
    idle();
    bus.stallF = 1;
    repeat (3) apply();
    chk("j_pend", 32'(bus.pend), 32'd1);
    bus.stallF = 0;
    apply();
    chk("j_pcF", bus.pcF, 32'h8000_0100);
    chk("j_pend_clr", 32'(bus.pend), 32'd0);

    // Exception overrides a pending redirect while stalled
    bus.validD = 1; bus.jumpD = 1; bus.stallF = 1;
    bus.pcplus4D = 32'h0040_0000; bus.instr_indexD = 26'h0000100;
    apply();
    idle();
    bus.stallF = 1; bus.flush_exc = 1; bus.exc_pc = 32'hBFC0_0380;
    apply();
    chk("exc_pcF", bus.pcF, 32'hBFC0_0380);
    chk("exc_pend", 32'(bus.pend), 32'd0);
    idle();
    apply();
    chk("exc_discard", bus.pcF, 32'hBFC0_0384);

    // Requests that must not redirect
    bus.validD = 1; bus.branchD = 1; bus.takenD = 0; bus.pcplus4D = 32'h500; bus.immD = 32'h10;
    apply();
    idle(); bus.validD = 0; bus.jumpD = 1; bus.instr_indexD = 26'h123;
    apply();
    idle(); bus.validD = 1; bus.stallD = 1; bus.jrD = 1; bus.rs_valD = 32'h4000;
    apply();
    chk("noreq_pcF", bus.pcF, 32'hBFC0_0390);
    idle(); bus.validD = 1; bus.jrD = 1; bus.rs_valD = 32'h2;
    apply();
    chk("jr_misalign", 32'(bus.misalignF), 32'd1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      bus.stallF       = ($urandom_range(2) == 0);
      bus.stallD       = ($urandom_range(4) == 0);
      bus.validD       = ($urandom_range(5) != 0);
      bus.branchD      = $urandom_range(1);
      bus.takenD       = $urandom_range(1);
      bus.jumpD        = ($urandom_range(4) == 0);
      bus.jrD          = ($urandom_range(5) == 0);
      bus.pcplus4D     = $urandom() & 32'hFFFF_FFFC;
      bus.immD         = {{16{1'b0}}, 16'($urandom())};
      if (bus.immD[15]) bus.immD[31:16] = 16'hFFFF;
      bus.instr_indexD = 26'($urandom());
      bus.rs_valD      = ($urandom_range(7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      bus.flush_exc    = ($urandom_range(15) == 0);
      bus.exc_pc       = $urandom() & 32'hFFFF_FFFC;
      apply();
    end

`ifdef BRANCH_STATS_EN
    chk("branch_cnt", bus.branch_cnt, br_m);
    chk("taken_cnt", bus.taken_cnt, tk_m);
`endif

    // Asynchronous reset mid-run
    idle();
    bus.stallF = 1; bus.validD = 1; bus.jumpD = 1; bus.instr_indexD = 26'h77;
    apply();
    rst = 1'b1;
    #1;
    chk("async_rst_pcF", bus.pcF, RESET_PC);
    chk("async_rst_pend", 32'(bus.pend), 32'd0);
    chk("async_rst_redirect", 32'(bus.redirect), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle();
    repeat (2) apply();

`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.validD = 1; bus.branchD = 1; bus.takenD = (i < 3);
      bus.pcplus4D = 32'h1000; bus.immD = 32'h4;
      apply();
    end
    chk("branch_cnt5", bus.branch_cnt, 32'd5);
    chk("taken_cnt3", bus.taken_cnt, 32'd3);
`endif

    idle();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
